// File: rtl/bitclk_scheduler_pkg.sv
// Shared types and constants for the bit-clock scheduler and its divider.
package bitclk_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam int unsigned DEF_LEN_W      = 8;
  localparam int unsigned DEF_GAP_CYCLES = 2;
  // Divider half-period in enabled system cycles; shared with the divider instance.
  localparam int unsigned CLK_PER_BIT    = 7;

  // Index width for a count of n items (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bitclk_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester after the last owner wins.
module bitclk_scheduler_rr_arbiter
  import bitclk_scheduler_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  winner,
  output logic [IDX_W-1:0] win_idx
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan from last+1 around the ring and keep the first active request.
  always_comb begin
    winner  = '0;
    win_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((32'(last) + k) % NREQ);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
    if (found) winner = NREQ'(1) << win_idx;
  end

endmodule

// File: rtl/bitclk_scheduler.sv
// Shares one external bit-clock divider between NREQ requesters, one burst at a time.
module bitclk_scheduler
  import bitclk_scheduler_pkg::*;
#(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned LEN_W      = DEF_LEN_W,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*LEN_W-1:0]   len,
  input  logic                    gen_clk,
  output logic                    gen_enable,
  output logic [NREQ-1:0]         grant,
  output logic                    bit_strobe,
  output logic [LEN_W-1:0]        bit_idx,
  output logic                    done,
  output logic                    aborted,
  output logic                    busy
);

  localparam int unsigned IDX_W = idx_width(NREQ);
  localparam int unsigned GAP_W = idx_width(GAP_CYCLES);

  state_t           state, state_n;
  logic [NREQ-1:0]  req_q;
  logic             gen_clk_q;
  logic [IDX_W-1:0] owner_idx, owner_idx_n;
  logic [IDX_W-1:0] last_idx, last_idx_n;
  logic [LEN_W-1:0] len_q, len_q_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic             abort_pend, abort_pend_n;

  logic             gen_enable_n, bit_strobe_n, done_n, aborted_n, busy_n;
  logic [NREQ-1:0]  grant_n;
  logic [LEN_W-1:0] bit_idx_n;

  logic [NREQ-1:0]  win_onehot;
  logic [IDX_W-1:0] win_idx;
  logic [LEN_W-1:0] len_sel;
  logic             rise;
  logic             owner_req;
  logic             last_bit;

  bitclk_scheduler_rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req     (req_q),
    .last    (last_idx),
    .winner  (win_onehot),
    .win_idx (win_idx)
  );

  assign rise      = gen_clk & ~gen_clk_q;
  assign owner_req = |(req_q & grant);
  assign last_bit  = (bit_idx == len_q - LEN_W'(1));

  // Burst length of the current arbitration winner.
  always_comb begin
    len_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == IDX_W'(i)) len_sel = len[i*LEN_W +: LEN_W];
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_n      = state;
    owner_idx_n  = owner_idx;
    last_idx_n   = last_idx;
    len_q_n      = len_q;
    gap_cnt_n    = gap_cnt;
    abort_pend_n = abort_pend;
    grant_n      = grant;
    bit_idx_n    = bit_idx;
    gen_enable_n = gen_enable;
    bit_strobe_n = 1'b0;
    done_n       = 1'b0;
    aborted_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req_q) begin
          grant_n      = win_onehot;
          owner_idx_n  = win_idx;
          len_q_n      = len_sel;
          bit_idx_n    = '0;
          abort_pend_n = 1'b0;
          if (len_sel != '0) begin
            state_n      = ST_RUN;
            gen_enable_n = 1'b1;
          end else begin
            state_n = ST_FIN;
          end
        end
      end
      ST_RUN: begin
        if (rise) begin
          bit_strobe_n = 1'b1;
          bit_idx_n    = bit_idx + LEN_W'(1);
        end
        // Completion takes precedence over a simultaneous request drop.
        if (rise && last_bit) begin
          state_n      = ST_FIN;
          gen_enable_n = 1'b0;
        end else if (!owner_req) begin
          state_n      = ST_FIN;
          gen_enable_n = 1'b0;
          abort_pend_n = 1'b1;
        end
      end
      ST_FIN: begin
        done_n       = 1'b1;
        aborted_n    = abort_pend;
        gen_enable_n = 1'b0;
        last_idx_n   = owner_idx;
        gap_cnt_n    = GAP_W'(GAP_CYCLES - 1);
        state_n      = ST_GAP;
      end
      ST_GAP: begin
        grant_n      = '0;
        gen_enable_n = 1'b0;
        if (gap_cnt == '0) state_n = ST_IDLE;
        else               gap_cnt_n = gap_cnt - GAP_W'(1);
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  // State, bookkeeping and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_q      <= '0;
      gen_clk_q  <= 1'b0;
      owner_idx  <= '0;
      last_idx   <= IDX_W'(NREQ - 1);
      len_q      <= '0;
      gap_cnt    <= '0;
      abort_pend <= 1'b0;
      gen_enable <= 1'b0;
      grant      <= '0;
      bit_strobe <= 1'b0;
      bit_idx    <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      req_q      <= req;
      gen_clk_q  <= gen_clk;
      owner_idx  <= owner_idx_n;
      last_idx   <= last_idx_n;
      len_q      <= len_q_n;
      gap_cnt    <= gap_cnt_n;
      abort_pend <= abort_pend_n;
      gen_enable <= gen_enable_n;
      grant      <= grant_n;
      bit_strobe <= bit_strobe_n;
      bit_idx    <= bit_idx_n;
      done       <= done_n;
      aborted    <= aborted_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_bitclk_scheduler.sv
// Directed bench for bitclk_scheduler with a behavioural divider model.
module tb_bitclk_scheduler;
  import bitclk_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] len;
  logic        gen_clk;
  logic        gen_enable;
  logic [1:0]  grant;
  logic        bit_strobe;
  logic [7:0]  bit_idx;
  logic        done;
  logic        aborted;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] div_cnt;
  logic        div_phase;

  bitclk_scheduler #(
    .NREQ       (2),
    .LEN_W      (8),
    .GAP_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .len        (len),
    .gen_clk    (gen_clk),
    .gen_enable (gen_enable),
    .grant      (grant),
    .bit_strobe (bit_strobe),
    .bit_idx    (bit_idx),
    .done       (done),
    .aborted    (aborted),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Divider: phase toggles every CLK_PER_BIT enabled cycles, output registered once more.
  always @(posedge clk) begin
    if (rst) begin
      div_cnt   <= 0;
      div_phase <= 1'b0;
      gen_clk   <= 1'b0;
    end else begin
      if (gen_enable) begin
        if (div_cnt == CLK_PER_BIT - 1) begin
          div_cnt   <= 0;
          div_phase <= ~div_phase;
        end else begin
          div_cnt <= div_cnt + 1;
        end
      end else begin
        div_cnt <= 0;
      end
      gen_clk <= div_phase;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Cycles from now until the next strobe (bounded).
  task automatic wait_strobe(output int k);
    k = 0;
    do begin
      step(1);
      k++;
    end while (!bit_strobe && k < 300);
  endtask

  initial begin
    int k;
    int ns;
    int en_bad;

    rst = 1'b1;
    req = 2'b00;
    len = 16'h0000;
    step(3);
    check("rst_enable",  32'(gen_enable), 0);
    check("rst_grant",   32'(grant),      0);
    check("rst_busy",    32'(busy),       0);
    check("rst_bit_idx", 32'(bit_idx),    0);
    check("rst_done",    32'(done),       0);
    check("rst_strobe",  32'(bit_strobe), 0);
    check("rst_aborted", 32'(aborted),    0);
    rst = 1'b0;
    step(2);

    // Single burst, divider starts low.
    len = 16'h0004;
    req = 2'b01;
    step(1);
    check("t1_grant_latency", 32'(grant), 0);
    step(1);
    check("t1_grant",   32'(grant),      1);
    check("t1_enable",  32'(gen_enable), 1);
    check("t1_busy",    32'(busy),       1);
    check("t1_idx0",    32'(bit_idx),    0);
    wait_strobe(k);
    check("t1_first_strobe", 32'(k), 9);
    check("t1_idx1", 32'(bit_idx), 1);
    for (int i = 2; i <= 4; i++) begin
      wait_strobe(k);
      check("t1_spacing", 32'(k), 14);
      check("t1_idx", 32'(bit_idx), 32'(i));
      check("t1_enable_run", 32'(gen_enable), (i < 4) ? 1 : 0);
    end
    step(1);
    check("t1_done",       32'(done),       1);
    check("t1_aborted",    32'(aborted),    0);
    check("t1_done_grant", 32'(grant),      1);
    check("t1_no_strobe",  32'(bit_strobe), 0);
    req = 2'b00;
    step(1);
    check("t1_done_pulse", 32'(done),       0);
    check("t1_grant_clr",  32'(grant),      0);
    check("t1_gap_busy",   32'(busy),       1);
    check("t1_gap_enable", 32'(gen_enable), 0);
    step(3);

    // Divider left high from the previous burst.
    len = 16'h0003;
    req = 2'b01;
    step(2);
    check("t2_enable", 32'(gen_enable), 1);
    wait_strobe(k);
    check("t2_first_strobe", 32'(k), 16);
    wait_strobe(k);
    check("t2_spacing", 32'(k), 14);
    wait_strobe(k);
    check("t2_spacing", 32'(k), 14);
    step(1);
    check("t2_done",    32'(done),    1);
    check("t2_count",   32'(bit_idx), 3);
    check("t2_aborted", 32'(aborted), 0);
    req = 2'b00;
    step(4);

    // Zero-length burst.
    len = 16'h0000;
    req = 2'b01;
    step(2);
    check("t3_grant",  32'(grant),      1);
    check("t3_enable", 32'(gen_enable), 0);
    check("t3_early",  32'(done),       0);
    step(1);
    check("t3_done",    32'(done),       1);
    check("t3_enable2", 32'(gen_enable), 0);
    check("t3_strobe",  32'(bit_strobe), 0);
    check("t3_aborted", 32'(aborted),    0);
    check("t3_idx",     32'(bit_idx),    0);
    req = 2'b00;
    step(4);

    // Abort after the third strobe.
    len = 16'h000A;
    req = 2'b01;
    step(2);
    check("t4_enable", 32'(gen_enable), 1);
    for (int i = 0; i < 3; i++) wait_strobe(k);
    check("t4_idx3", 32'(bit_idx), 3);
    req = 2'b00;
    step(2);
    check("t4_enable_off", 32'(gen_enable), 0);
    check("t4_not_yet",    32'(done),       0);
    step(1);
    check("t4_done",    32'(done),       1);
    check("t4_aborted", 32'(aborted),    1);
    check("t4_idx",     32'(bit_idx),    3);
    check("t4_enable",  32'(gen_enable), 0);
    step(1);
    check("t4_enable_after", 32'(gen_enable), 0);
    check("t4_aborted_clr",  32'(aborted),    0);
    ns = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (bit_strobe) ns++;
    end
    check("t4_no_more_strobes", 32'(ns), 0);

    // Mid-burst reset with both requesting.
    len = 16'h0202;
    req = 2'b11;
    step(2);
    check("t5_grant_rr", 32'(grant),      2);
    check("t5_enable",   32'(gen_enable), 1);
    step(4);
    rst = 1'b1;
    step(1);
    check("t5_rst_enable", 32'(gen_enable), 0);
    check("t5_rst_grant",  32'(grant),      0);
    check("t5_rst_busy",   32'(busy),       0);
    check("t5_rst_idx",    32'(bit_idx),    0);
    check("t5_rst_done",   32'(done),       0);
    check("t5_rst_strobe", 32'(bit_strobe), 0);
    step(1);
    check("t5_rst_done2", 32'(done), 0);
    rst = 1'b0;

    // Fairness with both requests held.
    for (int b = 0; b < 4; b++) begin
      k = 0;
      while (grant == 2'b00 && k < 50) begin
        step(1);
        k++;
      end
      check("fair_grant", 32'(grant), (b % 2 == 0) ? 1 : 2);
      ns = 0;
      k  = 0;
      while (!done && k < 400) begin
        step(1);
        k++;
        if (bit_strobe) ns++;
      end
      check("fair_strobes",    32'(ns),    2);
      check("fair_done_grant", 32'(grant), (b % 2 == 0) ? 1 : 2);
      check("fair_aborted",    32'(aborted), 0);
      step(1);
      k      = 1;
      en_bad = 0;
      while (grant == 2'b00 && k < 50) begin
        if (gen_enable) en_bad++;
        step(1);
        k++;
      end
      check("fair_gap_len",    32'(k),      3);
      check("fair_gap_enable", 32'(en_bad), 0);
    end
    rst = 1'b1;
    req = 2'b00;
    step(2);
    rst = 1'b0;
    step(1);

    // Maximum burst length.
    len = 16'h00FF;
    req = 2'b01;
    step(2);
    check("t6_grant", 32'(grant), 1);
    ns = 0;
    k  = 0;
    while (!done && k < 5000) begin
      step(1);
      k++;
      if (bit_strobe) ns++;
    end
    check("t6_done",    32'(done),    1);
    check("t6_strobes", 32'(ns),      255);
    check("t6_idx",     32'(bit_idx), 255);
    check("t6_aborted", 32'(aborted), 0);
    req = 2'b00;
    step(4);
    check("t6_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitclk_scheduler.md
# bitclk_scheduler

Sequences and shares one external bit-clock divider (enable in, divided clock out, toggling every `CLK_PER_BIT` enabled cycles) between `NREQ` serial requesters. A requester asks for a burst of N bit periods. The scheduler grants one requester at a time in round-robin order, enables the divider for exactly N rising edges of its output, and strobes each bit boundary. It then releases the divider and moves on. It sits between the sensor-side serial engines and the shared divider.

## Interface
- `NREQ`, 2: number of requesters (2..8).
- `LEN_W`, 8: width of each burst-length field.
- `GAP_CYCLES`, 2: minimum cycles with the divider enable low between bursts (≥1, so the divider counter clears).
- `clk`  in  1: system clock, all logic on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  NREQ: level request per requester; held until `done` or dropped to abort.
- `len`  in  NREQ*LEN_W: burst length in bit periods, requester i at `[i*LEN_W +: LEN_W]`; sampled at grant.
- `gen_clk`  in  1: divided clock returned by the divider.
- `gen_enable`  out  1: divider enable.
- `grant`  out  NREQ: one-hot owner; all-zero when idle.
- `bit_strobe`  out  1: one-cycle pulse per detected rising edge of `gen_clk` while running.
- `bit_idx`  out  LEN_W: index of the current bit, 0-based; increments after each strobe.
- `done`  out  1: one-cycle pulse at burst end, coincident with the last `grant` cycle.
- `aborted`  out  1: valid with `done`; 1 = burst ended by request drop.
- `busy`  out  1: high in every non-IDLE state.

## Operation
- States: IDLE, RUN, FIN, GAP.
- **IDLE.** If any `req` bit is set, the round-robin pick starts at the requester after the last owner (after reset, requester 0 has priority). Latch `len` of the winner, set `grant`, and clear `bit_idx`.
  - `len`≠0: go to RUN and set `gen_enable`.
  - `len`=0: go to FIN; `gen_enable` stays low.
- **RUN.**
  - Rising-edge detection: `gen_clk & ~gen_clk_q`, where `gen_clk_q` is a registered copy of `gen_clk`. `gen_clk_q` is not cleared between bursts, so a divider left high does not produce a false edge.
  - Each detected edge pulses `bit_strobe` and increments `bit_idx`.
  - When the strobe for bit `len-1` fires, go to FIN.
  - If the owner's `req` falls, go to FIN with `aborted` set. If both happen in the same cycle, the strobe fires and completion wins (`aborted`=0).
- **FIN.** One cycle: `done`=1, `grant` held, `gen_enable`=0. Go to GAP.
- **GAP.**
  - `grant` is cleared; `gen_enable` stays 0 for `GAP_CYCLES` cycles.
  - Requests are ignored; the last-owner pointer is updated.
  - Then go to IDLE.
- Arithmetic:
  - The bit counter is LEN_W bits and is compared against `len-1` only when `len`≠0, so there is no wrap.
  - `len`=2^LEN_W−1 must work.
- Reset:
  - Outputs go to `gen_enable`=0, `grant`=0, `bit_strobe`=0, `bit_idx`=0, `done`=0, `aborted`=0, `busy`=0.
  - State returns to IDLE, the round-robin pointer points at requester 0 next, and `gen_clk_q`=0.
  - Reset mid-burst drops the enable on the next edge; no `done` is issued.

## Timing
- All outputs are registered.
- `req` seen high at edge t: `grant`, `busy` and `gen_enable` are high after edge t+1.
- Strobe spacing in steady state is exactly 2·CLK_PER_BIT cycles.
- First strobe comes CLK_PER_BIT+2 cycles after `gen_enable` rises if `gen_clk` starts low, and 2·CLK_PER_BIT+2 if it starts high.
- `done` appears the cycle after the final strobe.
- Next grant comes no earlier than GAP_CYCLES+1 cycles after `done`.
- Requests arriving during RUN, FIN or GAP wait; none are lost while held.

## Structure
- Shared package holds:
  - state encoding constants;
  - default `LEN_W` and `GAP_CYCLES`;
  - the CLK_PER_BIT value shared with the divider instance.
- Sub-module `rr_arbiter`: inputs `req` vector and last-owner index; outputs one-hot winner and its index (combinational pick, pointer registered in the parent).
- The divider itself stays external; the scheduler only drives its enable.

## Test plan
- **Single burst.** Setup: NREQ=2, CLK_PER_BIT=7, reset-clean divider, `req`=01, len0=4.
  - Required: `gen_enable` high for 4 strobes spaced 14 cycles, first strobe 9 cycles after enable.
  - `bit_idx` 0→4; one `done` with `aborted`=0; `grant` back to 00.
- **Fairness.** Stimulus: `req`=11 held continuously, len=2 each.
  - Required: grants alternate 01,10,01,10.
  - Each burst has 2 strobes, with `gen_enable` low for ≥2 cycles between bursts.
- **Zero length.** Stimulus: `req`=01, len0=0.
  - Required: `gen_enable` never rises, no strobe, `done` two cycles after `req`.
- **Abort.** Stimulus: len0=10, `req`0 dropped after the 3rd strobe.
  - Required: `done`=1 with `aborted`=1, `bit_idx`=3, enable low next cycle, no further strobes.
- **Divider left high.** Stimulus: start a burst with `gen_clk` initially high.
  - Required: no strobe on the first enabled cycle; first strobe 16 cycles after enable; strobe count equals `len` exactly.
- **Mid-burst reset.** Stimulus: `rst` pulsed during RUN with `req`=11.
  - Required: all outputs zero after the edge, no `done`.
  - Next grant goes to requester 0.
